// File: rtl/cpu_ctrl_pkg.sv
// Shared constants for the accumulator CPU control sequencer:
// opcodes, control-word bit positions and the FSM state encoding.
package cpu_ctrl_pkg;

  localparam logic [7:0] OP_STORE  = 8'h01;
  localparam logic [7:0] OP_LOAD   = 8'h02;
  localparam logic [7:0] OP_ADD    = 8'h03;
  localparam logic [7:0] OP_SUB    = 8'h04;
  localparam logic [7:0] OP_JMPGEZ = 8'h05;
  localparam logic [7:0] OP_JMP    = 8'h06;
  localparam logic [7:0] OP_HALT   = 8'h07;
  localparam logic [7:0] OP_MPY    = 8'h08;
  localparam logic [7:0] OP_AND    = 8'h0A;
  localparam logic [7:0] OP_OR     = 8'h0B;
  localparam logic [7:0] OP_NOT    = 8'h0C;
  localparam logic [7:0] OP_SHR    = 8'h0D;
  localparam logic [7:0] OP_SHL    = 8'h0E;

  localparam int C_MAR_PC  = 0;
  localparam int C_MEM_RD  = 1;
  localparam int C_IR_MBR  = 2;
  localparam int C_MAR_IR  = 3;
  localparam int C_MEM_WR  = 4;
  localparam int C_MBR_ACC = 5;
  localparam int C_PC_INC  = 6;
  localparam int C_BR_MBR  = 7;
  localparam int C_ACC_ALU = 9;
  localparam int C_ACC_MBR = 10;
  localparam int C_PC_IR   = 14;

  typedef enum logic [3:0] {
    S_IDLE = 4'd0,
    S_F0   = 4'd1,
    S_F1   = 4'd2,
    S_F2   = 4'd3,
    S_DEC  = 4'd4,
    S_EXA  = 4'd5,
    S_EXR  = 4'd6,
    S_EXL  = 4'd7,
    S_EXB  = 4'd8,
    S_EXU  = 4'd9,
    S_EXM  = 4'd10,
    S_EXW  = 4'd11,
    S_EXJ  = 4'd12,
    S_HALT = 4'd13
  } state_t;

endpackage

// File: rtl/cpu_ctrl_decode.sv
// Combinational decode of the sequencer state into the datapath control word.
// Only C9 looks at an input, so the ALU result is written in the cycle it is ready.
module cpu_ctrl_decode
  import cpu_ctrl_pkg::*;
(
  input  logic [3:0]  state,
  input  logic        alu_done,
  output logic [15:0] ctrl
);

  always_comb begin
    ctrl = '0;
    case (state_t'(state))
      S_F0:  ctrl[C_MAR_PC] = 1'b1;
      S_F1:  ctrl[C_MEM_RD] = 1'b1;
      S_F2: begin
        ctrl[C_IR_MBR] = 1'b1;
        ctrl[C_PC_INC] = 1'b1;
      end
      S_EXA: ctrl[C_MAR_IR]  = 1'b1;
      S_EXR: ctrl[C_MEM_RD]  = 1'b1;
      S_EXL: ctrl[C_ACC_MBR] = 1'b1;
      S_EXB: ctrl[C_BR_MBR]  = 1'b1;
      S_EXU: ctrl[C_ACC_ALU] = alu_done;
      S_EXM: ctrl[C_MBR_ACC] = 1'b1;
      S_EXW: ctrl[C_MEM_WR]  = 1'b1;
      S_EXJ: ctrl[C_PC_IR]   = 1'b1;
      default: ctrl = '0;
    endcase
  end

endmodule

// File: rtl/cpu_ctrl_seq.sv
// Hardwired fetch/decode/execute sequencer for the accumulator CPU.
// Holds memory strobes MEM_WAIT extra cycles and waits on the ALU in EXU.
module cpu_ctrl_seq
  import cpu_ctrl_pkg::*;
#(
  parameter int MEM_WAIT = 0,
  parameter int CW       = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [7:0]  opcode,
  input  logic        acc_neg,
  input  logic        alu_done,
  output logic [15:0] ctrl,
  output logic [3:0]  alu_op,
  output logic        alu_start,
  output logic        halted,
  output logic        illegal
);

  state_t        state, state_next;
  logic [CW-1:0] wait_cnt;
  logic          exu_first;
  logic          set_illegal;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_next;
  end

  // After DEC the latched low nibble is enough to steer the shared EXA/EXR path,
  // because undefined opcodes never get past DEC.
  always_comb begin
    state_next  = state;
    set_illegal = 1'b0;
    case (state)
      S_IDLE: if (start) state_next = S_F0;
      S_F0:   state_next = S_F1;
      S_F1:   if (wait_cnt == '0) state_next = S_F2;
      S_F2:   state_next = S_DEC;
      S_DEC: begin
        case (opcode)
          OP_LOAD, OP_STORE, OP_ADD, OP_SUB,
          OP_MPY, OP_AND, OP_OR:       state_next = S_EXA;
          OP_NOT, OP_SHR, OP_SHL:      state_next = S_EXU;
          OP_JMP:                      state_next = S_EXJ;
          OP_JMPGEZ:                   state_next = acc_neg ? S_F0 : S_EXJ;
          OP_HALT:                     state_next = S_HALT;
          default: begin
            set_illegal = 1'b1;
            state_next  = S_HALT;
          end
        endcase
      end
      S_EXA:  state_next = (alu_op == OP_STORE[3:0]) ? S_EXM : S_EXR;
      S_EXR: begin
        if (wait_cnt == '0)
          state_next = (alu_op == OP_LOAD[3:0]) ? S_EXL : S_EXB;
      end
      S_EXL:  state_next = S_F0;
      S_EXB:  state_next = S_EXU;
      S_EXU:  if (alu_done) state_next = S_F0;
      S_EXM:  state_next = S_EXW;
      S_EXW:  if (wait_cnt == '0) state_next = S_F0;
      S_EXJ:  state_next = S_F0;
      S_HALT: state_next = S_HALT;
      default: state_next = S_IDLE;
    endcase
  end

  // Every held state is entered from a different state, so a state change reloads the count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wait_cnt  <= '0;
      exu_first <= 1'b0;
      alu_op    <= '0;
      illegal   <= 1'b0;
    end else begin
      if (state_next != state)  wait_cnt <= CW'(MEM_WAIT);
      else if (wait_cnt != '0)  wait_cnt <= wait_cnt - 1'b1;
      exu_first <= (state_next == S_EXU) && (state != S_EXU);
      if (state == S_DEC) alu_op  <= opcode[3:0];
      if (set_illegal)    illegal <= 1'b1;
    end
  end

  assign alu_start = exu_first;
  assign halted    = (state == S_HALT);

  cpu_ctrl_decode u_decode (
    .state    (state),
    .alu_done (alu_done),
    .ctrl     (ctrl)
  );

endmodule

// File: tb/tb_cpu_ctrl_seq.sv
// Self-checking bench: two sequencers (MEM_WAIT 0 and 3) against a per-instruction
// cycle-list model built from the instruction timing rules.
module tb_cpu_ctrl_seq;

  localparam int MW0 = 0;
  localparam int MW1 = 3;

  localparam logic [15:0] C0  = 16'h0001;
  localparam logic [15:0] C1  = 16'h0002;
  localparam logic [15:0] C2  = 16'h0004;
  localparam logic [15:0] C3  = 16'h0008;
  localparam logic [15:0] C4  = 16'h0010;
  localparam logic [15:0] C5  = 16'h0020;
  localparam logic [15:0] C6  = 16'h0040;
  localparam logic [15:0] C7  = 16'h0080;
  localparam logic [15:0] C9  = 16'h0200;
  localparam logic [15:0] C10 = 16'h0400;
  localparam logic [15:0] C14 = 16'h4000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start [2];
  logic [7:0]  opcode [2];
  logic        acc_neg [2];
  logic        alu_done [2];
  logic [15:0] ctrl [2];
  logic [3:0]  alu_op [2];
  logic        alu_start [2];
  logic        halted [2];
  logic        illegal [2];

  always #5 clk = ~clk;

  cpu_ctrl_seq #(.MEM_WAIT(MW0), .CW(4)) dut0 (
    .clk(clk), .rst_n(rst_n), .start(start[0]), .opcode(opcode[0]),
    .acc_neg(acc_neg[0]), .alu_done(alu_done[0]), .ctrl(ctrl[0]),
    .alu_op(alu_op[0]), .alu_start(alu_start[0]), .halted(halted[0]),
    .illegal(illegal[0])
  );

  cpu_ctrl_seq #(.MEM_WAIT(MW1), .CW(4)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start[1]), .opcode(opcode[1]),
    .acc_neg(acc_neg[1]), .alu_done(alu_done[1]), .ctrl(ctrl[1]),
    .alu_op(alu_op[1]), .alu_start(alu_start[1]), .halted(halted[1]),
    .illegal(illegal[1])
  );

  typedef struct {
    logic [15:0] ctrl;
    logic        astart;
    logic        halt;
    logic        ill;
    logic [3:0]  aop;
    logic        done;
  } exp_t;

  typedef struct {
    logic [7:0] op;
    logic       neg;
    int         dly;
    int         len;
  } vec_t;

  int         n_vec = 0;
  int         n_fail = 0;
  exp_t       q[$];
  logic [3:0] m_aop [2];
  logic       m_ill [2];
  logic [7:0] legal_ops [12] = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06,
                                 8'h08, 8'h0A, 8'h0B, 8'h0C, 8'h0D, 8'h0E};
  vec_t       tbl [13];

  function automatic logic rbit();
    return 1'($urandom_range(0, 1));
  endfunction

  function automatic exp_t mk(int k, logic [15:0] c, logic as, logic h, logic d);
    exp_t e;
    e.ctrl = c; e.astart = as; e.halt = h; e.ill = m_ill[k]; e.aop = m_aop[k]; e.done = d;
    return e;
  endfunction

  task automatic push(int k, logic [15:0] c, logic as, logic d, logic h);
    q.push_back(mk(k, c, as, h, d));
  endtask

  // Expected cycle-by-cycle outputs of one instruction, from F0 up to its last state.
  task automatic build(int k, logic [7:0] op, logic neg, int dly);
    int mw;
    mw = (k == 0) ? MW0 : MW1;
    q.delete();
    push(k, C0, 0, rbit(), 0);
    for (int j = 0; j <= mw; j++) push(k, C1, 0, rbit(), 0);
    push(k, C2 | C6, 0, rbit(), 0);
    push(k, 16'h0, 0, rbit(), 0);
    m_aop[k] = op[3:0];
    case (op)
      8'h02: begin
        push(k, C3, 0, rbit(), 0);
        for (int j = 0; j <= mw; j++) push(k, C1, 0, rbit(), 0);
        push(k, C10, 0, rbit(), 0);
      end
      8'h03, 8'h04, 8'h08, 8'h0A, 8'h0B: begin
        push(k, C3, 0, rbit(), 0);
        for (int j = 0; j <= mw; j++) push(k, C1, 0, rbit(), 0);
        push(k, C7, 0, rbit(), 0);
        for (int j = 0; j <= dly; j++) push(k, (j == dly) ? C9 : 16'h0, j == 0, j == dly, 0);
      end
      8'h01: begin
        push(k, C3, 0, rbit(), 0);
        push(k, C5, 0, rbit(), 0);
        for (int j = 0; j <= mw; j++) push(k, C4, 0, rbit(), 0);
      end
      8'h0C, 8'h0D, 8'h0E:
        for (int j = 0; j <= dly; j++) push(k, (j == dly) ? C9 : 16'h0, j == 0, j == dly, 0);
      8'h06: push(k, C14, 0, rbit(), 0);
      8'h05: if (!neg) push(k, C14, 0, rbit(), 0);
      8'h07: push(k, 16'h0, 0, rbit(), 1);
      default: begin
        m_ill[k] = 1'b1;
        push(k, 16'h0, 0, rbit(), 1);
      end
    endcase
  endtask

  task automatic check_output(int k, exp_t e, string tag, int cyc);
    n_vec++;
    if (ctrl[k] !== e.ctrl || alu_start[k] !== e.astart || halted[k] !== e.halt ||
        illegal[k] !== e.ill || alu_op[k] !== e.aop) begin
      n_fail++;
      $display("[TB] FAIL %s dut%0d cyc %0d: got ctrl=%h start=%b halt=%b ill=%b op=%h, want ctrl=%h start=%b halt=%b ill=%b op=%h",
               tag, k, cyc, ctrl[k], alu_start[k], halted[k], illegal[k], alu_op[k],
               e.ctrl, e.astart, e.halt, e.ill, e.aop);
    end
  endtask

  // Runs len cycles of one instruction starting in F0 (len<0 uses the model length).
  task automatic apply_stimulus(int k, logic [7:0] op, logic neg, int dly, int len, bit chk_f0);
    int   n;
    exp_t e;
    build(k, op, neg, dly);
    n = (len < 0) ? q.size() : len;
    opcode[k]  = op;
    acc_neg[k] = neg;
    for (int i = 0; i < n; i++) begin
      if (i < q.size()) e = q[i];
      else              e = mk(k, C0, 0, 0, 0);
      alu_done[k] = e.done;
      @(negedge clk);
      check_output(k, e, $sformatf("op%h", op), i);
      @(posedge clk);
      #1;
    end
    alu_done[k] = 1'b0;
    if (chk_f0) check_output(k, mk(k, C0, 0, 0, 0), $sformatf("ret_f0_op%h", op), n);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    for (int k = 0; k < 2; k++) begin
      start[k] = 1'b0; alu_done[k] = 1'b0; acc_neg[k] = 1'b0; opcode[k] = 8'h00;
      m_aop[k] = 4'h0; m_ill[k] = 1'b0;
    end
    #3;
    for (int k = 0; k < 2; k++) check_output(k, mk(k, 16'h0, 0, 0, 0), "reset", 0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic start_cpu(int k);
    start[k] = 1'b1;
    @(posedge clk);
    #1 start[k] = 1'b0;
  endtask

  task automatic halt_hold(int k, int n);
    start[k] = 1'b1;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      check_output(k, mk(k, 16'h0, 0, 1, 0), "halt_hold", i);
      @(posedge clk);
      #1 start[k] = 1'b0;
    end
  endtask

  initial begin
    tbl[0]  = '{8'h02, 1'b0, 0, 7};
    tbl[1]  = '{8'h03, 1'b0, 1, 9};
    tbl[2]  = '{8'h04, 1'b0, 0, 8};
    tbl[3]  = '{8'h0A, 1'b0, 2, 10};
    tbl[4]  = '{8'h0B, 1'b1, 0, 8};
    tbl[5]  = '{8'h0C, 1'b0, 1, 6};
    tbl[6]  = '{8'h0D, 1'b0, 0, 5};
    tbl[7]  = '{8'h0E, 1'b0, 3, 8};
    tbl[8]  = '{8'h01, 1'b0, 0, 7};
    tbl[9]  = '{8'h06, 1'b1, 0, 5};
    tbl[10] = '{8'h05, 1'b0, 0, 5};
    tbl[11] = '{8'h05, 1'b1, 0, 4};
    tbl[12] = '{8'h08, 1'b0, 5, 13};

    do_reset();
    start_cpu(0);
    foreach (tbl[i]) apply_stimulus(0, tbl[i].op, tbl[i].neg, tbl[i].dly, tbl[i].len, 1'b1);
    for (int i = 0; i < 30; i++)
      apply_stimulus(0, legal_ops[$urandom_range(0, 11)], rbit(), $urandom_range(0, 4), -1, 1'b1);
    apply_stimulus(0, 8'h07, 1'b0, 0, -1, 1'b0);
    halt_hold(0, 4);

    do_reset();
    start_cpu(0);
    apply_stimulus(0, 8'hFF, 1'b0, 0, -1, 1'b0);
    halt_hold(0, 4);
    do_reset();

    start_cpu(1);
    apply_stimulus(1, 8'h01, 1'b0, 0, 13, 1'b1);
    apply_stimulus(1, 8'h02, 1'b0, 0, 13, 1'b1);
    apply_stimulus(1, 8'h08, 1'b1, 5, 19, 1'b1);
    for (int i = 0; i < 10; i++)
      apply_stimulus(1, legal_ops[$urandom_range(0, 11)], rbit(), $urandom_range(0, 4), -1, 1'b1);

    // Abort a LOAD while its memory read strobe is being held in EXR.
    do_reset();
    start_cpu(1);
    apply_stimulus(1, 8'h02, 1'b0, 0, 9, 1'b0);
    check_output(1, mk(1, C1, 0, 0, 0), "exr_held", 9);
    #2 rst_n = 1'b0;
    #1 m_aop[1] = 4'h0;
    check_output(1, mk(1, 16'h0, 0, 0, 0), "reset_abort", 0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_output(1, mk(1, 16'h0, 0, 0, 0), "idle_wait", i);
      @(posedge clk);
      #1;
    end
    start_cpu(1);
    check_output(1, mk(1, C0, 0, 0, 0), "restart", 0);
    apply_stimulus(1, 8'h02, 1'b0, 0, -1, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
